usb_rx_ctrl: RTL and testbench
==============================

// Module: usb_rx_ctrl
// PURPOSE
//  Receive-side packet controller behind the NRZI decoder in the USB 2.0 PHY.
//  Consumes decoded NRZ bits: hunts SYNC, removes stuffed bits, packs bytes LSB-first,
//  detects EOP (SE0), flags stuff/alignment/length errors, re-arms the decoder between packets.
//  Output byte stream feeds the PHY-to-link (UTMI-style) RX interface.
// PARAMETERS
//  SYNC_ZEROS_MIN  3     min consecutive 0s before the SYNC-terminating 1 (tolerates hub-truncated SYNC)
//  STUFF_LEN       6     consecutive 1s after which the next bit is a stuffed 0
//  MAX_BYTES       1027  max bytes per packet incl. PID/CRC; exceeding it = length error
// PORTS
//  i_clk         in   1  clock
//  i_rst_n       in   1  asynchronous active-low reset
//  i_bit         in   1  decoded NRZ bit from NRZI decoder
//  i_bit_valid   in   1  i_bit/i_se0 qualifier, one strobe per line bit
//  i_se0         in   1  line in SE0 at this bit strobe
//  o_dec_clr     out  1  1-cycle pulse: reset decoder history to idle (J)
//  o_rx_active   out  1  packet in progress (SYNC accepted, no EOP/error yet)
//  o_byte        out  8  received byte, valid only with o_byte_valid
//  o_byte_valid  out  1  1-cycle strobe per assembled byte
//  o_eop         out  1  1-cycle strobe: packet terminated by SE0
//  o_err_stuff   out  1  1-cycle strobe: 1 where stuffed 0 required
//  o_err_align   out  1  1-cycle strobe, with o_eop: EOP on non-byte boundary or zero bytes
//  o_err_len     out  1  1-cycle strobe: byte count > MAX_BYTES
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; zero_cnt, ones_cnt, bit_cnt, byte_cnt, shift reg 0.
//  All outputs registered; every counter/state update occurs only on cycles with i_bit_valid=1.
//  States: IDLE, DATA, ABORT.
//  IDLE: i_se0 -> zero_cnt=0. i_bit=0 -> zero_cnt++ (saturates at SYNC_ZEROS_MIN).
//   i_bit=1 with zero_cnt>=SYNC_ZEROS_MIN -> DATA, o_rx_active=1 next cycle, ones_cnt=1
//   (SYNC's final 1 counts toward stuffing), bit_cnt=0, byte_cnt=0. Otherwise i_bit=1 -> zero_cnt=0.
//  DATA, priority order per strobe:
//   1) i_se0: o_eop=1; o_err_align=1 if bit_cnt!=0 or byte_cnt==0; partial byte discarded;
//      o_rx_active=0; o_dec_clr=1; -> IDLE. All pulses in same cycle.
//   2) ones_cnt==STUFF_LEN: stuff slot. i_bit=0 -> dropped, ones_cnt=0.
//      i_bit=1 -> o_err_stuff=1, o_rx_active=0, -> ABORT.
//   3) data bit: shift in at MSB (shift right), LSB-first order; i_bit=1 ? ones_cnt++ : ones_cnt=0;
//      bit_cnt++; on 8th bit: o_byte=assembled byte, o_byte_valid=1, bit_cnt=0, byte_cnt++.
//      If that byte would make byte_cnt>MAX_BYTES: no o_byte_valid, o_err_len=1,
//      o_rx_active=0, -> ABORT.
//   Stuff check precedes data, so a stuffed 0 crossing a byte boundary never counts as data.
//  ABORT: ignore bits; on i_se0 strobe -> o_dec_clr=1, -> IDLE (no o_eop).
//  Latency: o_byte_valid asserted the cycle after the strobe carrying the byte's 8th bit.
//  Simultaneous: i_se0 wins over stuff/data evaluation on same strobe.
//  i_bit_valid=0 cycles: state held, all strobes 0.
//  Reset mid-packet: immediate return to IDLE, outputs 0, no o_eop/o_dec_clr pulse.
//  byte_cnt width $clog2(MAX_BYTES+2), saturating; never wraps.
// TESTING
//  SYNC 0000_0001, bits 1,0,1,0,0,1,0,1, SE0 -> one o_byte_valid 0xA5; then o_eop+o_dec_clr, no errors.
//  SYNC, data 1,1,1,1,1,(stuffed 0),1,1,1, SE0 -> o_byte 0xFF, stuffed bit dropped, clean EOP.
//  SYNC, seven 1s -> o_err_stuff on 6th data bit strobe; rx_active drops; bits ignored until SE0, then o_dec_clr.
//  SYNC, 0xA5 + 4 bits, SE0 -> byte 0xA5, then o_eop with o_err_align; partial nibble never output.
//  SYNC_ZEROS_MIN=3: 0,0,1 -> stays IDLE; 0,0,0,1 -> rx_active; MAX_BYTES=2, 3 bytes -> 2 bytes + o_err_len.
//  Assert i_rst_n low mid-byte -> all outputs 0 at once; next valid SYNC received normally.

Source files
------------

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl
//   Receive-side packet controller that sits behind the NRZI decoder of a
//   USB 2.0 PHY. It consumes decoded NRZ bits, hunts for SYNC, removes
//   stuffed bits, packs bytes LSB-first, detects EOP (SE0), and flags
//   stuffing, alignment and length errors. Between packets it pulses
//   dec_clr so the NRZI decoder restarts from idle (J).
//
// Ports
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_bit          decoded NRZ bit
//   i_bit_valid    qualifier for i_bit / i_se0, one strobe per line bit
//   i_se0          line is in SE0 at this strobe
//   o_dec_clr      1-cycle pulse: reset NRZI decoder history
//   o_rx_active    packet in progress
//   o_byte         received byte, meaningful only with o_byte_valid
//   o_byte_valid   1-cycle strobe per assembled byte
//   o_eop          1-cycle strobe: packet terminated by SE0
//   o_err_stuff    1-cycle strobe: a 1 arrived where a stuffed 0 was due
//   o_err_align    1-cycle strobe with o_eop: EOP mid-byte or empty packet
//   o_err_len      1-cycle strobe: packet longer than MAX_BYTES
module usb_rx_ctrl #(
    parameter int SYNC_ZEROS_MIN = 3,
    parameter int STUFF_LEN      = 6,
    parameter int MAX_BYTES      = 1027
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    input  logic       i_se0,
    output logic       o_dec_clr,
    output logic       o_rx_active,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_eop,
    output logic       o_err_stuff,
    output logic       o_err_align,
    output logic       o_err_len
);

    localparam int ZW = $clog2(SYNC_ZEROS_MIN + 1);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int BW = $clog2(MAX_BYTES + 2);

    localparam logic [ZW-1:0] ZEROS_MIN = ZW'(SYNC_ZEROS_MIN);
    localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LEN);
    localparam logic [OW-1:0] ONES_ONE  = OW'(1);
    localparam logic [BW-1:0] BYTES_MAX = BW'(MAX_BYTES);
    localparam logic [BW-1:0] BYTES_SAT = {BW{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ABORT
    } state_t;

    state_t          state;
    logic [ZW-1:0]   zero_cnt;
    logic [OW-1:0]   ones_cnt;
    logic [2:0]      bit_cnt;
    logic [BW-1:0]   byte_cnt;
    logic [7:0]      shift_reg;
    logic [7:0]      shift_in;

    // Bits arrive LSB-first, so each new bit enters at the MSB and the
    // first bit of the byte ends up in bit 0 after eight shifts.
    assign shift_in = {i_bit, shift_reg[7:1]};

    // NOTE: every register here, including the shift register, is reset so
    // that a mid-packet reset leaves no stale byte or counter behind.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            zero_cnt     <= '0;
            ones_cnt     <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            shift_reg    <= '0;
            o_dec_clr    <= 1'b0;
            o_rx_active  <= 1'b0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_eop        <= 1'b0;
            o_err_stuff  <= 1'b0;
            o_err_align  <= 1'b0;
            o_err_len    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the strobe defaults
            // below are overridden later in the same block where needed.
            o_dec_clr    <= 1'b0;
            o_byte_valid <= 1'b0;
            o_eop        <= 1'b0;
            o_err_stuff  <= 1'b0;
            o_err_align  <= 1'b0;
            o_err_len    <= 1'b0;

            if (i_bit_valid) begin
                case (state)
                    IDLE: begin
                        if (i_se0) begin
                            zero_cnt <= '0;
                        end else if (!i_bit) begin
                            if (zero_cnt < ZEROS_MIN) zero_cnt <= zero_cnt + 1'b1;
                        end else if (zero_cnt >= ZEROS_MIN) begin
                            // SYNC's closing 1 already counts toward stuffing.
                            state       <= DATA;
                            o_rx_active <= 1'b1;
                            ones_cnt    <= ONES_ONE;
                            bit_cnt     <= '0;
                            byte_cnt    <= '0;
                            zero_cnt    <= '0;
                        end else begin
                            zero_cnt <= '0;
                        end
                    end

                    DATA: begin
                        if (i_se0) begin
                            // Any partial byte in shift_reg is simply dropped.
                            o_eop       <= 1'b1;
                            o_err_align <= (bit_cnt != 3'd0) || (byte_cnt == '0);
                            o_rx_active <= 1'b0;
                            o_dec_clr   <= 1'b1;
                            state       <= IDLE;
                        end else if (ones_cnt == ONES_MAX) begin
                            // Stuff slot: checked before data so a stuffed 0
                            // at a byte boundary never lands in a byte.
                            if (!i_bit) begin
                                ones_cnt <= '0;
                            end else begin
                                o_err_stuff <= 1'b1;
                                o_rx_active <= 1'b0;
                                state       <= ABORT;
                            end
                        end else begin
                            shift_reg <= shift_in;
                            ones_cnt  <= i_bit ? ones_cnt + 1'b1 : '0;
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                if (byte_cnt >= BYTES_MAX) begin
                                    o_err_len   <= 1'b1;
                                    o_rx_active <= 1'b0;
                                    state       <= ABORT;
                                end else begin
                                    o_byte       <= shift_in;
                                    o_byte_valid <= 1'b1;
                                    if (byte_cnt != BYTES_SAT) byte_cnt <= byte_cnt + 1'b1;
                                end
                            end
                        end
                    end

                    ABORT: begin
                        if (i_se0) begin
                            o_dec_clr <= 1'b1;
                            state     <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl
//   Directed bench for usb_rx_ctrl, built with MAX_BYTES=2 so the length
//   limit is reachable. Each line-bit strobe occupies one clock followed by
//   one idle clock; outputs are sampled 1 time unit after each rising edge.
module tb_usb_rx_ctrl;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic       se0;
    logic       dec_clr;
    logic       rx_active;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       eop;
    logic       err_stuff;
    logic       err_align;
    logic       err_len;

    int checks;
    int failures;

    // Per-scenario log of what the DUT produced.
    logic [7:0] byte_q[$];
    int idx;
    int byte_at;
    int stuff_at;
    int len_at;
    int n_eop;
    int n_clr;
    int n_eop_clr;
    int n_stuff;
    int n_align;
    int n_len;
    int gap_pulse;

    usb_rx_ctrl #(
        .SYNC_ZEROS_MIN(3),
        .STUFF_LEN     (6),
        .MAX_BYTES     (2)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_bit       (bit_in),
        .i_bit_valid (bit_valid),
        .i_se0       (se0),
        .o_dec_clr   (dec_clr),
        .o_rx_active (rx_active),
        .o_byte      (rx_byte),
        .o_byte_valid(byte_valid),
        .o_eop       (eop),
        .o_err_stuff (err_stuff),
        .o_err_align (err_align),
        .o_err_len   (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_log();
        byte_q.delete();
        idx       = 0;
        byte_at   = -1;
        stuff_at  = -1;
        len_at    = -1;
        n_eop     = 0;
        n_clr     = 0;
        n_eop_clr = 0;
        n_stuff   = 0;
        n_align   = 0;
        n_len     = 0;
        gap_pulse = 0;
    endtask

    task automatic sample(input bit is_strobe);
        if (is_strobe) idx++;
        if (!is_strobe && (byte_valid || eop || dec_clr || err_stuff || err_align || err_len))
            gap_pulse++;
        if (byte_valid) begin
            byte_q.push_back(rx_byte);
            byte_at = idx;
        end
        if (eop) n_eop++;
        if (dec_clr) n_clr++;
        if (eop && dec_clr) n_eop_clr++;
        if (err_stuff) begin
            n_stuff++;
            stuff_at = idx;
        end
        if (err_align) n_align++;
        if (err_len) begin
            n_len++;
            len_at = idx;
        end
    endtask

    // One line-bit strobe, then one cycle with i_bit_valid low.
    task automatic strobe(input logic b, input logic s);
        @(negedge clk);
        bit_in    = b;
        se0       = s;
        bit_valid = 1'b1;
        @(posedge clk);
        #1 sample(1'b1);
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        se0       = 1'b0;
        @(posedge clk);
        #1 sample(1'b0);
    endtask

    // Full SYNC 0000_0001 in line order; data strobe index restarts after it.
    task automatic send_sync();
        for (int i = 0; i < 7; i++) strobe(1'b0, 1'b0);
        strobe(1'b1, 1'b0);
        idx = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) strobe(b[i], 1'b0);
    endtask

    task automatic send_se0();
        strobe(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if ({dec_clr, rx_active, rx_byte, byte_valid, eop, err_stuff, err_align, err_len} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {dec_clr, rx_active, rx_byte, byte_valid, eop, err_stuff, err_align, err_len});
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (rx_active !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_active got=%b exp=0", rx_active);
        end
        checks++;
    endtask

    task automatic test_basic();
        clear_log();
        send_sync();
        if (rx_active !== 1'b1) begin
            failures++;
            $display("FAIL basic_active got=%b exp=1", rx_active);
        end
        checks++;
        send_byte(8'hA5);
        send_se0();
        if (byte_q.size() !== 1 || byte_q[0] !== 8'hA5) begin
            failures++;
            $display("FAIL basic_byte got_n=%0d got=%h exp_n=1 exp=a5", byte_q.size(), byte_q[0]);
        end
        checks++;
        if (byte_at !== 8) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=8", byte_at);
        end
        checks++;
        if (n_eop !== 1 || n_clr !== 1 || n_eop_clr !== 1) begin
            failures++;
            $display("FAIL basic_eop got eop=%0d clr=%0d same=%0d exp 1/1/1", n_eop, n_clr, n_eop_clr);
        end
        checks++;
        if (n_stuff + n_align + n_len !== 0 || rx_active !== 1'b0) begin
            failures++;
            $display("FAIL basic_clean got errs=%0d active=%b exp 0/0", n_stuff + n_align + n_len, rx_active);
        end
        checks++;
        if (gap_pulse !== 0) begin
            failures++;
            $display("FAIL basic_gap got=%0d exp=0", gap_pulse);
        end
        checks++;
    endtask

    task automatic test_stuff_drop();
        clear_log();
        send_sync();
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
        send_se0();
        if (byte_q.size() !== 1 || byte_q[0] !== 8'hFF) begin
            failures++;
            $display("FAIL stuff_byte got_n=%0d got=%h exp_n=1 exp=ff", byte_q.size(), byte_q[0]);
        end
        checks++;
        if (n_eop !== 1 || n_align !== 0 || n_stuff !== 0) begin
            failures++;
            $display("FAIL stuff_eop got eop=%0d align=%0d stuff=%0d exp 1/0/0", n_eop, n_align, n_stuff);
        end
        checks++;
    endtask

    task automatic test_stuff_err();
        clear_log();
        send_sync();
        for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0);
        if (n_stuff !== 1 || stuff_at !== 6) begin
            failures++;
            $display("FAIL stuff_err got n=%0d at=%0d exp n=1 at=6", n_stuff, stuff_at);
        end
        checks++;
        if (rx_active !== 1'b0) begin
            failures++;
            $display("FAIL stuff_err_active got=%b exp=0", rx_active);
        end
        checks++;
        strobe(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) strobe(1'b1, 1'b0);
        if (n_clr !== 0 || byte_q.size() !== 0) begin
            failures++;
            $display("FAIL stuff_err_ignore got clr=%0d bytes=%0d exp 0/0", n_clr, byte_q.size());
        end
        checks++;
        send_se0();
        if (n_clr !== 1 || n_eop !== 0 || rx_active !== 1'b0) begin
            failures++;
            $display("FAIL stuff_err_end got clr=%0d eop=%0d active=%b exp 1/0/0", n_clr, n_eop, rx_active);
        end
        checks++;
    endtask

    task automatic test_align();
        clear_log();
        send_sync();
        send_byte(8'hA5);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        send_se0();
        if (byte_q.size() !== 1 || byte_q[0] !== 8'hA5) begin
            failures++;
            $display("FAIL align_byte got_n=%0d got=%h exp_n=1 exp=a5", byte_q.size(), byte_q[0]);
        end
        checks++;
        if (n_eop !== 1 || n_align !== 1 || n_clr !== 1) begin
            failures++;
            $display("FAIL align_flag got eop=%0d align=%0d clr=%0d exp 1/1/1", n_eop, n_align, n_clr);
        end
        checks++;
        // Packet that ends right after SYNC carries zero bytes.
        clear_log();
        send_sync();
        send_se0();
        if (n_eop !== 1 || n_align !== 1 || byte_q.size() !== 0) begin
            failures++;
            $display("FAIL align_empty got eop=%0d align=%0d bytes=%0d exp 1/1/0", n_eop, n_align, byte_q.size());
        end
        checks++;
    endtask

    task automatic test_sync_min();
        clear_log();
        send_se0();
        if (n_clr !== 0 || n_eop !== 0) begin
            failures++;
            $display("FAIL sync_idle_se0 got clr=%0d eop=%0d exp 0/0", n_clr, n_eop);
        end
        checks++;
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b1, 1'b0);
        if (rx_active !== 1'b0) begin
            failures++;
            $display("FAIL sync_two_zeros got=%b exp=0", rx_active);
        end
        checks++;
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b1, 1'b0);
        if (rx_active !== 1'b1) begin
            failures++;
            $display("FAIL sync_three_zeros got=%b exp=1", rx_active);
        end
        checks++;
        send_se0();
        if (n_eop !== 1 || n_align !== 1) begin
            failures++;
            $display("FAIL sync_short_eop got eop=%0d align=%0d exp 1/1", n_eop, n_align);
        end
        checks++;
    endtask

    task automatic test_len();
        clear_log();
        send_sync();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        if (byte_q.size() !== 2 || byte_q[0] !== 8'h11 || byte_q[1] !== 8'h22) begin
            failures++;
            $display("FAIL len_bytes got_n=%0d got=%h,%h exp_n=2 exp=11,22",
                     byte_q.size(), byte_q[0], byte_q[1]);
        end
        checks++;
        if (n_len !== 1 || len_at !== 24 || rx_active !== 1'b0) begin
            failures++;
            $display("FAIL len_err got n=%0d at=%0d active=%b exp 1/24/0", n_len, len_at, rx_active);
        end
        checks++;
        send_se0();
        if (n_clr !== 1 || n_eop !== 0) begin
            failures++;
            $display("FAIL len_end got clr=%0d eop=%0d exp 1/0", n_clr, n_eop);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_sync();
        send_byte(8'h3C);
        send_byte(8'hC3);
        send_se0();
        send_sync();
        send_byte(8'hC3);
        send_byte(8'h3C);
        send_se0();
        if (byte_q.size() !== 4 || byte_q[0] !== 8'h3C || byte_q[1] !== 8'hC3 ||
            byte_q[2] !== 8'hC3 || byte_q[3] !== 8'h3C) begin
            failures++;
            $display("FAIL b2b_bytes got_n=%0d got=%h,%h,%h,%h exp_n=4 exp=3c,c3,c3,3c",
                     byte_q.size(), byte_q[0], byte_q[1], byte_q[2], byte_q[3]);
        end
        checks++;
        if (n_eop !== 2 || n_clr !== 2 || n_len + n_align + n_stuff !== 0) begin
            failures++;
            $display("FAIL b2b_eop got eop=%0d clr=%0d errs=%0d exp 2/2/0",
                     n_eop, n_clr, n_len + n_align + n_stuff);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_sync();
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b0);
        if (rx_active !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre_active got=%b exp=1", rx_active);
        end
        checks++;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        if ({dec_clr, rx_active, rx_byte, byte_valid, eop, err_stuff, err_align, err_len} !== 14'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b exp=0",
                     {dec_clr, rx_active, rx_byte, byte_valid, eop, err_stuff, err_align, err_len});
        end
        checks++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        send_sync();
        send_byte(8'hA5);
        send_se0();
        if (byte_q.size() !== 1 || byte_q[0] !== 8'hA5 || n_eop !== 1 || n_align !== 0) begin
            failures++;
            $display("FAIL rstmid_recover got_n=%0d got=%h eop=%0d align=%0d exp 1/a5/1/0",
                     byte_q.size(), byte_q[0], n_eop, n_align);
        end
        checks++;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        se0       = 1'b0;
        clear_log();
        test_reset();
        test_basic();
        test_stuff_drop();
        test_stuff_err();
        test_align();
        test_sync_min();
        test_len();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
